// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, owner, gnt0, gnt1, accept;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [1:0] op_q;
  // On a tie the requester that did not win last time is granted
  assign gnt0 = req0_valid & (~req1_valid | last_grant);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
  assign accept = (state == IDLE) & (gnt0 | gnt1);
  assign req0_ready = rst_n & (state == IDLE) & gnt0;
  assign req1_ready = rst_n & (state == IDLE) & gnt1;
  assign resp0_valid = (state == RESP) & ~owner;
  assign resp1_valid = (state == RESP) & owner;
  assign resp0_result = res_q;
  assign resp1_result = res_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? EXEC : IDLE;
    else if (state == EXEC) state_nx = RESP;
    else if (state == RESP) state_nx = (owner ? resp1_ready : resp0_ready) ? IDLE : RESP;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= gnt1;
        last_grant <= gnt1;
        a_q <= gnt1 ? req1_a : req0_a;
        b_q <= gnt1 ? req1_b : req0_b;
        op_q <= gnt1 ? req1_op : req0_op;
      end
      if (state == EXEC) res_q <= alu_result;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] rq_v = '0, rq_r, rs_v, rs_r = '0;
  logic [1:0][W-1:0] rq_a = '0, rq_b = '0, rs_res;
  logic [1:0][1:0] rq_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic model_lg = 1'b1;
  int tests = 0, fails = 0;

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: return a | b;
      default: return ~(a & b);
    endcase
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_op);
  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq_v[0]), .req0_ready(rq_r[0]), .req0_a(rq_a[0]), .req0_b(rq_b[0]), .req0_op(rq_op[0]),
    .req1_valid(rq_v[1]), .req1_ready(rq_r[1]), .req1_a(rq_a[1]), .req1_b(rq_b[1]), .req1_op(rq_op[1]),
    .resp0_valid(rs_v[0]), .resp0_ready(rs_r[0]), .resp0_result(rs_res[0]),
    .resp1_valid(rs_v[1]), .resp1_ready(rs_r[1]), .resp1_result(rs_res[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    rq_v = '0;
    rs_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_lg = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rq_v = 2'b11;
    rs_r = 2'b11;
    rq_a[0] = 32'hA; rq_a[1] = 32'hB; rq_b[0] = 32'hC; rq_b[1] = 32'hD;
    repeat (2) @(negedge clk);
    tests++; if (rq_r !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", rq_r); end
    tests++; if (rs_v !== 2'b00) begin fails++; $display("FAIL reset_resp_valid got %b want 00", rs_v); end
    tests++; if ({alu_a, alu_b, alu_op} !== '0) begin fails++; $display("FAIL reset_alu got %h %h %b want 0 0 00", alu_a, alu_b, alu_op); end
    tests++; if (rs_res !== '0) begin fails++; $display("FAIL reset_result got %h want 0", rs_res); end
    rq_v = '0;
    rs_r = '0;
    rst_n = 1'b1;
    model_lg = 1'b1;
  endtask

  task automatic run_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] exp, input string nm);
    logic [1:0] one;
    one = 2'b01 << n;
    @(negedge clk);
    rq_a[n] = a; rq_b[n] = b; rq_op[n] = op; rq_v = one;
    #1;
    tests++; if (rq_r !== one) begin fails++; $display("FAIL %s_ready got %b want %b", nm, rq_r, one); end
    @(negedge clk);
    rq_v = '0;
    tests++; if (rs_v !== 2'b00) begin fails++; $display("FAIL %s_exec_valid got %b want 00", nm, rs_v); end
    tests++; if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin fails++; $display("FAIL %s_alu_operands got %h %h %b want %h %h %b", nm, alu_a, alu_b, alu_op, a, b, op); end
    @(negedge clk);
    tests++; if (rs_v !== one) begin fails++; $display("FAIL %s_resp_valid got %b want %b", nm, rs_v, one); end
    tests++; if (rs_res[n] !== exp) begin fails++; $display("FAIL %s_result got %h want %h", nm, rs_res[n], exp); end
    rs_r = one;
    @(negedge clk);
    rs_r = '0;
    tests++; if (rs_v !== 2'b00) begin fails++; $display("FAIL %s_resp_done got %b want 00", nm, rs_v); end
    model_lg = n[0];
  endtask

  task automatic test_back_to_back();
    int c[2] = '{0, 0};
    bit fresh[2] = '{1'b1, 1'b1};
    int order[$];
    logic [W-1:0] expq0[$], expq1[$];
    int cyc = 0;
    do_reset();
    rs_r = 2'b11;
    while ((order.size() < 4 || expq0.size() + expq1.size() > 0) && cyc < 60) begin
      for (int n = 0; n < 2; n++) begin
        if (fresh[n]) begin rq_a[n] = $urandom; rq_b[n] = $urandom; rq_op[n] = 2'($urandom); fresh[n] = 1'b0; end
        rq_v[n] = c[n] < 2;
      end
      #1;
      if (cyc == 0) begin
        tests++; if (rq_r !== 2'b01) begin fails++; $display("FAIL b2b_first_grant got %b want 01", rq_r); end
      end
      if (rs_v[0]) begin
        tests++;
        if (expq0.size() == 0) begin fails++; $display("FAIL b2b_resp0 got spurious %h want none", rs_res[0]); end
        else if (rs_res[0] !== expq0[0]) begin fails++; $display("FAIL b2b_resp0 got %h want %h", rs_res[0], expq0[0]); end
        if (expq0.size() > 0) void'(expq0.pop_front());
      end
      if (rs_v[1]) begin
        tests++;
        if (expq1.size() == 0) begin fails++; $display("FAIL b2b_resp1 got spurious %h want none", rs_res[1]); end
        else if (rs_res[1] !== expq1[0]) begin fails++; $display("FAIL b2b_resp1 got %h want %h", rs_res[1], expq1[0]); end
        if (expq1.size() > 0) void'(expq1.pop_front());
      end
      for (int n = 0; n < 2; n++) begin
        if (rq_v[n] && rq_r[n]) begin
          order.push_back(n);
          if (n == 0) expq0.push_back(ref_alu(rq_a[0], rq_b[0], rq_op[0]));
          else expq1.push_back(ref_alu(rq_a[1], rq_b[1], rq_op[1]));
          c[n]++;
          fresh[n] = 1'b1;
          model_lg = n[0];
        end
      end
      @(negedge clk);
      cyc++;
    end
    rq_v = '0;
    rs_r = '0;
    tests++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      fails++; $display("FAIL b2b_order got %p want 0 1 0 1", order);
    end
  endtask

  task automatic test_resp_stall();
    logic [W-1:0] r0, r1;
    do_reset();
    rq_a[0] = $urandom; rq_b[0] = $urandom; rq_op[0] = 2'($urandom);
    rq_a[1] = $urandom; rq_b[1] = $urandom; rq_op[1] = 2'($urandom);
    r0 = ref_alu(rq_a[0], rq_b[0], rq_op[0]);
    r1 = ref_alu(rq_a[1], rq_b[1], rq_op[1]);
    rq_v = 2'b11;
    #1;
    tests++; if (rq_r !== 2'b01) begin fails++; $display("FAIL stall_grant0 got %b want 01", rq_r); end
    @(negedge clk);
    rq_v = 2'b10;
    @(negedge clk);
    rs_r = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (rs_v !== 2'b01 || rs_res[0] !== r0) begin fails++; $display("FAIL stall_hold got %b %h want 01 %h", rs_v, rs_res[0], r0); end
      tests++; if (rq_r !== 2'b00) begin fails++; $display("FAIL stall_req_ready got %b want 00", rq_r); end
    end
    rs_r = 2'b01;
    @(negedge clk);
    rs_r = '0;
    #1;
    tests++; if (rq_r !== 2'b10) begin fails++; $display("FAIL stall_grant1 got %b want 10", rq_r); end
    @(negedge clk);
    rq_v = '0;
    @(negedge clk);
    tests++; if (rs_v !== 2'b10 || rs_res[1] !== r1) begin fails++; $display("FAIL stall_resp1 got %b %h want 10 %h", rs_v, rs_res[1], r1); end
    rs_r = 2'b10;
    @(negedge clk);
    rs_r = '0;
    model_lg = 1'b1;
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    rq_a[0] = 32'h1234_5678; rq_b[0] = 32'h0101_0101; rq_op[0] = 2'b10; rq_v = 2'b01;
    @(negedge clk);
    rq_v = '0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (rs_v !== 2'b00 || rq_r !== 2'b00) begin fails++; $display("FAIL rstexec_handshake got %b %b want 00 00", rs_v, rq_r); end
    tests++; if ({alu_a, alu_b, alu_op} !== '0 || rs_res !== '0) begin fails++; $display("FAIL rstexec_regs got %h %h %b %h want 0", alu_a, alu_b, alu_op, rs_res); end
    @(negedge clk);
    rst_n = 1'b1;
    model_lg = 1'b1;
    rs_r = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (rs_v !== 2'b00) begin fails++; $display("FAIL rstexec_no_resp got %b want 00", rs_v); end
    end
    rs_r = '0;
    run_op(1, 32'h0F0F_0000, 32'h00F0_000F, 2'b10, 32'h0FFF_000F, "rstexec_new_or");
  endtask

  task automatic test_random();
    bit pend[2] = '{1'b0, 1'b0};
    bit busy = 1'b0;
    int own = 0, ph = 0, g;
    logic [W-1:0] exp = '0;
    logic [1:0] want;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          rq_a[n] = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
          rq_b[n] = $urandom;
          rq_op[n] = 2'($urandom);
        end
        rq_v[n] = pend[n];
      end
      #1;
      if (busy) begin
        ph++;
        want = (ph >= 2) ? (2'b01 << own) : 2'b00;
        tests++; if (rq_r !== 2'b00) begin fails++; $display("FAIL rand_ready_busy got %b want 00", rq_r); end
        tests++; if (rs_v !== want) begin fails++; $display("FAIL rand_resp_valid got %b want %b", rs_v, want); end
        if (ph >= 2) begin
          tests++; if (rs_res[own] !== exp) begin fails++; $display("FAIL rand_result got %h want %h", rs_res[own], exp); end
        end
        if (ph > 64) begin
          tests++; fails++; $display("FAIL rand_timeout got busy %0d cycles want completion", ph);
          break;
        end
        rs_r = 2'($urandom);
        if (ph >= 2 && rs_r[own]) busy = 1'b0;
      end else begin
        g = (pend[0] && pend[1]) ? (model_lg ? 0 : 1) : pend[0] ? 0 : pend[1] ? 1 : -1;
        want = (g < 0) ? 2'b00 : (2'b01 << g);
        tests++; if (rq_r !== want) begin fails++; $display("FAIL rand_grant got %b want %b", rq_r, want); end
        tests++; if (rs_v !== 2'b00) begin fails++; $display("FAIL rand_idle_valid got %b want 00", rs_v); end
        if (g >= 0) begin
          busy = 1'b1;
          ph = 0;
          own = g;
          exp = ref_alu(rq_a[g], rq_b[g], rq_op[g]);
          model_lg = g[0];
          pend[g] = 1'b0;
        end
        rs_r = 2'($urandom);
      end
    end
    rq_v = '0;
    rs_r = 2'b11;
    repeat (4) @(negedge clk);
    rs_r = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    run_op(0, 32'd5, 32'd7, 2'b00, 32'd12, "add_req0");
    run_op(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, "sub_req1");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, "nand_ones");
    run_op(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h0000_0000, "add_wrap");
    test_back_to_back();
    test_resp_stall();
    test_reset_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
